sram_tester: RTL

- Client-side initiator that drives the SRAM controller's request/ack interface to run a self-checking memory test.
- Writes an address-derived pattern to addresses 0..addr_last, then reads the same range back and compares each word.
- Reports pass/fail, a saturating error count and the first failing address and data.
- Sits between board-level start/status logic and the SRAM controller's client port.

---
 rtl/sram_tester_if.sv | 24 ++
 rtl/sram_tester.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_tester_if.sv
// Client-side request/ack bus between the memory tester and the SRAM controller.
// The master modport is the tester; the slave modport is the controller side.
interface sram_tester_if #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sram_req;
  logic                  sram_ack;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_rh_wl;
  logic [DATA_WIDTH-1:0] sram_data_w;
  logic [DATA_WIDTH-1:0] sram_data_r;
  logic                  sram_data_r_en;

  modport master (
    output sram_req, sram_addr, sram_rh_wl, sram_data_w,
    input  sram_ack, sram_data_r, sram_data_r_en
  );

  modport slave (
    input  sram_req, sram_addr, sram_rh_wl, sram_data_w,
    output sram_ack, sram_data_r, sram_data_r_en
  );
endinterface

// File: rtl/sram_tester.sv
// Self-checking SRAM test initiator: writes an address-derived pattern over 0..addr_last,
// reads it back and reports errors. Optional wait timeout: define SRAM_TESTER_TIMEOUT_EN.
module sram_tester #(
  parameter int unsigned ADDR_WIDTH     = 19,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ERR_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [ADDR_WIDTH-1:0] addr_last,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  timeout,
  sram_tester_if.master         bus
);

  if (ADDR_WIDTH < DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sram_tester: ADDR_WIDTH must be >= DATA_WIDTH and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_NEXT, RD_REQ, RD_WAIT, RD_NEXT, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic                  req_q, req_d;
  logic                  rh_wl_q, rh_wl_d;
  logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] fea_q, fea_d;
  logic [DATA_WIDTH-1:0] fed_q, fed_d;
  logic                  to_q, to_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  do_cmp;

`ifdef SRAM_TESTER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          in_wait;
`endif

  // Address-derived pattern: fold the upper address bits onto the low byte, then mix in the seed.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] s);
    logic [ADDR_WIDTH-1:0] sh;
    sh = a >> DATA_WIDTH;
    return a[DATA_WIDTH-1:0] ^ sh[DATA_WIDTH-1:0] ^ s;
  endfunction

  // Next-state and next-value logic for every register.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    seed_d   = seed_q;
    err_d    = err_q;
    fea_d    = fea_q;
    fed_d    = fed_q;
    to_d     = to_q;
    do_cmp   = 1'b0;
`ifdef SRAM_TESTER_TIMEOUT_EN
    wait_d   = '0;
    in_wait  = 1'b0;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d  = seed;
          last_d  = addr_last;
          err_d   = '0;
          fea_d   = '0;
          fed_d   = '0;
          to_d    = 1'b0;
          addr_d  = '0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (bus.sram_ack) state_d = WR_NEXT;
      end
      WR_NEXT: begin
        if (addr_q == last_q) begin
          addr_d  = '0;
          state_d = RD_REQ;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        if (bus.sram_ack) begin
          if (bus.sram_data_r_en) begin
            do_cmp  = 1'b1;
            state_d = RD_NEXT;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (bus.sram_data_r_en) begin
          do_cmp  = 1'b1;
          state_d = RD_NEXT;
        end
      end
      RD_NEXT: begin
        if (addr_q == last_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A nonzero count means an earlier mismatch already captured the first-error fields.
    if (do_cmp && (bus.sram_data_r != pat(addr_q, seed_q))) begin
      if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
      if (err_q == '0) begin
        fea_d = addr_q;
        fed_d = bus.sram_data_r;
      end
    end

`ifdef SRAM_TESTER_TIMEOUT_EN
    in_wait = (state_q == WR_REQ) || (state_q == RD_REQ) || (state_q == RD_WAIT);
    if (in_wait && (state_d == state_q)) begin
      if (wait_q == WAIT_LAST) begin
        state_d = DONE;
        to_d    = 1'b1;
      end else begin
        wait_d  = wait_q + TW'(1);
      end
    end
`endif

    // Outputs are registered from the next state so they line up with the state they describe.
    req_d    = (state_d == WR_REQ) || (state_d == RD_REQ);
    rh_wl_d  = (state_d == RD_REQ) ? 1'b1 : (state_d == WR_REQ) ? 1'b0 : rh_wl_q;
    data_w_d = (state_d == WR_REQ) ? pat(addr_d, seed_d) : data_w_q;
    busy_d   = (state_d != IDLE) && (state_d != DONE);
    done_d   = (state_d == DONE);
    pass_d   = done_d && (err_d == '0) && !to_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      seed_q   <= '0;
      req_q    <= 1'b0;
      rh_wl_q  <= 1'b0;
      data_w_q <= '0;
      err_q    <= '0;
      fea_q    <= '0;
      fed_q    <= '0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef SRAM_TESTER_TIMEOUT_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      seed_q   <= seed_d;
      req_q    <= req_d;
      rh_wl_q  <= rh_wl_d;
      data_w_q <= data_w_d;
      err_q    <= err_d;
      fea_q    <= fea_d;
      fed_q    <= fed_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
`ifdef SRAM_TESTER_TIMEOUT_EN
      wait_q   <= wait_d;
`endif
    end
  end

  assign bus.sram_req    = req_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_rh_wl  = rh_wl_q;
  assign bus.sram_data_w = data_w_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_addr  = fea_q;
  assign first_err_data  = fed_q;
  assign timeout         = to_q;

endmodule
